// File: rtl/adc_pkg.sv
// adc_pkg: definitions shared by the emulated ADC controller.
//   adc_state_e - controller state encoding (IDLE / CONV / DONE)
//   SAMPLE_L    - 16-entry base waveform used to synthesise samples
//   ch_w()      - width of a select field for n items, never less than 1
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } adc_state_e;

  localparam logic [7:0] SAMPLE_L [16] = '{
    8'h8B, 8'h8C, 8'h99, 8'h9B, 8'h93, 8'h82, 8'h97, 8'h90,
    8'h9F, 8'hD7, 8'h8D, 8'h9C, 8'h85, 8'h8A, 8'h91, 8'h8C
  };

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_sample_rom.sv
// adc_sample_rom: combinational sample generator.
//   i_ch     - channel number
//   i_idx    - per-channel sample index
//   o_sample - SAMPLE_L[i_idx mod 16] + 16*i_ch, wrapped to DATA_W bits
module adc_sample_rom
  import adc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CH_W   = 2,
  parameter int IDX_W  = 4
) (
  input  logic [CH_W-1:0]   i_ch,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [DATA_W-1:0] o_sample
);

  logic [3:0] w_lidx;

  // Index can be wider than the 16-entry table when DEPTH > 16.
  assign w_lidx = 4'(32'(i_idx) % 32'd16);

  // Channel offset is 16*c; truncation to DATA_W gives the required wrap.
  assign o_sample = DATA_W'(SAMPLE_L[w_lidx]) + DATA_W'({i_ch, 4'h0});

endmodule

// File: rtl/adc_mc.sv
// adc_mc: emulated multi-channel ADC conversion controller.
//   clk, rst      - clock, asynchronous active-high reset
//   req, ch       - conversion request (rising edge) and channel select
//   rdy           - one-cycle pulse when a conversion completes
//   busy          - high while converting or completing
//   dat, dat_ch   - last converted sample and its channel
//   ovr           - sticky: a request edge arrived while busy
//
// state | meaning
// IDLE  | waiting for a request edge
// CONV  | counting down the conversion latency
// DONE  | result just published (rdy high), returning to IDLE
module adc_mc
  import adc_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int DEPTH    = 16,
  parameter  int N_CH     = 4,
  parameter  int CONV_CYC = 4,
  localparam int CH_W     = ch_w(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [CH_W-1:0]   ch,
  output logic              rdy,
  output logic              busy,
  output logic [DATA_W-1:0] dat,
  output logic [CH_W-1:0]   dat_ch,
  output logic              ovr
);

  localparam int IDX_W = ch_w(DEPTH);
  localparam int CNT_W = ch_w(CONV_CYC);

  adc_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req_q;
  logic [CH_W-1:0]   r_ch;
  logic [IDX_W-1:0]  r_idx [N_CH];
  logic              r_rdy;
  logic [DATA_W-1:0] r_dat;
  logic [CH_W-1:0]   r_dat_ch;
  logic              r_ovr;

  logic              w_req_edge;
  logic [IDX_W-1:0]  w_idx_cur;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [DATA_W-1:0] w_sample;

  assign w_req_edge = req & ~r_req_q;
  assign w_idx_cur  = r_idx[r_ch];
  assign w_idx_nxt  = (w_idx_cur == IDX_W'(DEPTH - 1)) ? '0 : w_idx_cur + 1'b1;

  adc_sample_rom #(
    .DATA_W (DATA_W),
    .CH_W   (CH_W),
    .IDX_W  (IDX_W)
  ) u_rom (
    .i_ch     (r_ch),
    .i_idx    (w_idx_cur),
    .o_sample (w_sample)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_req_q  <= 1'b0;
      r_ch     <= '0;
      r_rdy    <= 1'b0;
      r_dat    <= '0;
      r_dat_ch <= '0;
      r_ovr    <= 1'b0;
      for (int c = 0; c < N_CH; c++) r_idx[c] <= '0;
    end else begin
      r_req_q <= req;
      r_rdy   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req_edge) begin
            r_ch    <= CH_W'(32'(ch) % 32'(N_CH));
            r_cnt   <= CNT_W'(CONV_CYC - 1);
            r_ovr   <= 1'b0;
            r_state <= CONV;
          end
        end
        CONV: begin
          if (w_req_edge) r_ovr <= 1'b1;
          if (r_cnt == '0) begin
            r_dat        <= w_sample;
            r_dat_ch     <= r_ch;
            r_rdy        <= 1'b1;
            r_idx[r_ch]  <= w_idx_nxt;
            r_state      <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          if (w_req_edge) r_ovr <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rdy    = r_rdy;
  assign busy   = (r_state != IDLE);
  assign dat    = r_dat;
  assign dat_ch = r_dat_ch;
  assign ovr    = r_ovr;

endmodule

// File: tb/tb_adc_mc.sv
module tb_adc_mc;

  localparam int CONV_CYC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [1:0] ch;
  logic       rdy;
  logic       busy;
  logic [7:0] dat;
  logic [1:0] dat_ch;
  logic       ovr;

  int n_chk  = 0;
  int n_fail = 0;
  int rdy_cnt = 0;
  int m_idx [4];
  logic [9:0] sb_q [$];
  logic [9:0] sb_e;

  logic [7:0] l_tb [16] = '{
    8'h8B, 8'h8C, 8'h99, 8'h9B, 8'h93, 8'h82, 8'h97, 8'h90,
    8'h9F, 8'hD7, 8'h8D, 8'h9C, 8'h85, 8'h8A, 8'h91, 8'h8C
  };

  adc_mc dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .ch     (ch),
    .rdy    (rdy),
    .busy   (busy),
    .dat    (dat),
    .dat_ch (dat_ch),
    .ovr    (ovr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input int c);
    logic [7:0] s;
    s = l_tb[m_idx[c] % 16] + 8'(16 * c);
    sb_q.push_back({2'(c), s});
    m_idx[c] = (m_idx[c] + 1) % 16;
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) m_idx[c] = 0;
  endtask

  // Scoreboard consumer: every completion must match the oldest expectation.
  always @(negedge clk) begin
    if (rdy === 1'b1) begin
      rdy_cnt++;
      check_val("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        check_val("dat", 32'(dat), 32'(sb_e[7:0]));
        check_val("dat_ch", 32'(dat_ch), 32'(sb_e[9:8]));
      end
    end
  end

  // One request pulse; checks rdy position and busy length relative to acceptance.
  task automatic convert(input int c);
    int rdy_at;
    int busy_n;
    @(negedge clk);
    req = 1'b1;
    ch  = 2'(c);
    sb_push(c);
    @(negedge clk);
    req = 1'b0;
    rdy_at = -1;
    busy_n = 0;
    for (int k = 0; k < 8; k++) begin
      if (rdy === 1'b1 && rdy_at < 0) rdy_at = k;
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
    end
    check_val("rdy_latency", 32'(rdy_at), 32'(CONV_CYC));
    check_val("busy_len", 32'(busy_n), 32'(CONV_CYC + 1));
  endtask

  task automatic check_zero_outputs(input string pfx);
    check_val({pfx, "_rdy"}, 32'(rdy), 0);
    check_val({pfx, "_busy"}, 32'(busy), 0);
    check_val({pfx, "_dat"}, 32'(dat), 0);
    check_val({pfx, "_dat_ch"}, 32'(dat_ch), 0);
    check_val({pfx, "_ovr"}, 32'(ovr), 0);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    req = 1'b0;
    ch  = 2'd0;
    model_reset();
    #1;
    check_zero_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // first conversion, then 16 more on ch0 to reach wrap-around
    convert(0);
    for (int n = 0; n < 16; n++) convert(0);

    // independent indices per channel
    convert(1);
    convert(0);
    convert(1);

    // overrun: edge two cycles into CONV
    base = rdy_cnt;
    @(negedge clk);
    req = 1'b1;
    ch  = 2'd3;
    sb_push(3);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    req = 1'b1;
    ch  = 2'd1;
    @(negedge clk);
    req = 1'b0;
    check_val("ovr_set", 32'(ovr), 1);
    check_val("busy_during_ovr", 32'(busy), 1);
    repeat (6) @(negedge clk);
    check_val("ovr_single_rdy", 32'(rdy_cnt - base), 1);
    check_val("ovr_sticky", 32'(ovr), 1);
    convert(2);
    check_val("ovr_cleared", 32'(ovr), 0);

    // reset mid-conversion aborts without rdy or index advance
    base = rdy_cnt;
    @(negedge clk);
    req = 1'b1;
    ch  = 2'd0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check_val("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check_zero_outputs("midrst");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_val("rst_no_rdy", 32'(rdy_cnt - base), 0);
    convert(0);

    // req held high: one conversion only
    base = rdy_cnt;
    @(negedge clk);
    req = 1'b1;
    ch  = 2'd2;
    sb_push(2);
    repeat (20) @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    check_val("held_one_rdy", 32'(rdy_cnt - base), 1);
    check_val("held_ovr", 32'(ovr), 0);
    check_val("held_dat", 32'(dat), 32'h AB);

    check_val("sb_drained", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
